cv32e40p_tmr_fault_handler: RTL and testbench

// Consumer end of the TMR voter fault flags. Collects per-voter fault flags and

---
 rtl/cv32e40p_tmr_fault_handler.sv | 118 +++++++++++
 tb/tb_cv32e40p_tmr_fault_handler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_fault_handler.sv
// cv32e40p_tmr_fault_handler: TMR fault sequencer (halt, resync, windowed escalation); optional log via CV32E40P_TMR_FAULT_LOG_EN
module cv32e40p_tmr_fault_handler #(
    parameter int NSRC          = 4,
    parameter int RESYNC_CYCLES = 2,
    parameter int FATAL_THRESH  = 3,
    parameter int WINDOW        = 1024,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSRC-1:0]         fault_i,
    input  logic                    halt_ack_i,
    input  logic                    clear_i,
    output logic                    halt_req_o,
    output logic                    resync_o,
    output logic                    busy_o,
    output logic                    fatal_o,
    output logic [CNT_W-1:0]        fault_cnt_o,
    output logic [NSRC-1:0]         fault_log_o,
    output logic [$clog2(NSRC)-1:0] first_src_o
);
    localparam int TW = $clog2(WINDOW);
    localparam int WW = $clog2(FATAL_THRESH + 1);
    localparam int RW = RESYNC_CYCLES > 1 ? $clog2(RESYNC_CYCLES) : 1;
    localparam int SW = $clog2(NSRC);

    typedef enum logic [1:0] {IDLE, HALT, RESYNC, FATAL} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    win_tmr;
    logic [WW-1:0]    win_cnt, win_base, win_cnt_nxt;
    logic [RW-1:0]    rs_cnt, rs_cnt_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wrap, event_hit;

    // The window count restarts on the timer's last cycle; a same-cycle event then counts as the first of the new window.
    assign wrap      = &win_tmr;
    assign event_hit = (state == IDLE) && |fault_i && !clear_i;

    // Window and lifetime counters: clear beats events, both saturate.
    always_comb begin
        win_base    = wrap ? '0 : win_cnt;
        win_cnt_nxt = clear_i ? '0
                    : event_hit ? (win_base == WW'(FATAL_THRESH) ? win_base : win_base + WW'(1))
                    : win_base;
        cnt_nxt     = clear_i ? '0
                    : (event_hit && !(&fault_cnt_o)) ? fault_cnt_o + CNT_W'(1)
                    : fault_cnt_o;
    end

    // Next-state logic for the recovery sequence.
    always_comb begin
        state_nxt  = state;
        rs_cnt_nxt = rs_cnt;
        case (state)
            IDLE:    if (event_hit) state_nxt = (win_cnt_nxt >= WW'(FATAL_THRESH)) ? FATAL : HALT;
            HALT:    if (halt_ack_i) begin
                         state_nxt  = RESYNC;
                         rs_cnt_nxt = RW'(RESYNC_CYCLES - 1);
                     end
            RESYNC:  if (rs_cnt == '0) state_nxt = IDLE;
                     else rs_cnt_nxt = rs_cnt - RW'(1);
            FATAL:   if (clear_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and outputs registered from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rs_cnt      <= '0;
            win_tmr     <= '0;
            win_cnt     <= '0;
            fault_cnt_o <= '0;
            halt_req_o  <= 1'b0;
            resync_o    <= 1'b0;
            busy_o      <= 1'b0;
            fatal_o     <= 1'b0;
        end else begin
            state       <= state_nxt;
            rs_cnt      <= rs_cnt_nxt;
            win_tmr     <= win_tmr + TW'(1);
            win_cnt     <= win_cnt_nxt;
            fault_cnt_o <= cnt_nxt;
            halt_req_o  <= state_nxt != IDLE;
            resync_o    <= state_nxt == RESYNC;
            busy_o      <= state_nxt != IDLE;
            fatal_o     <= state_nxt == FATAL;
        end
    end

`ifdef CV32E40P_TMR_FAULT_LOG_EN
    logic [SW-1:0] low_idx;

    // Lowest asserted source index; scanning downward leaves the smallest one.
    always_comb begin
        low_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (fault_i[i]) low_idx = SW'(i);
    end

    // An empty log means no event since reset/clear, so the next event sets first_src_o.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            fault_log_o <= '0;
            first_src_o <= '0;
        end else if (event_hit) begin
            fault_log_o <= fault_log_o | fault_i;
            if (fault_log_o == '0) first_src_o <= low_idx;
        end
    end
`else
    assign fault_log_o = '0;
    assign first_src_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_fault_handler.sv
// tb_cv32e40p_tmr_fault_handler: directed self-checking bench for the TMR fault handler
module tb_cv32e40p_tmr_fault_handler;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fault_i = '0;
    logic       halt_ack_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       halt_req_o, resync_o, busy_o, fatal_o;
    logic [7:0] fault_cnt_o;
    logic [3:0] fault_log_o;
    logic [1:0] first_src_o;
    int         n_cmp = 0;
    int         n_err = 0;
    int         ncyc = 0;

    cv32e40p_tmr_fault_handler dut (
        .clk(clk), .rst(rst), .fault_i(fault_i), .halt_ack_i(halt_ack_i), .clear_i(clear_i),
        .halt_req_o(halt_req_o), .resync_o(resync_o), .busy_o(busy_o), .fatal_o(fatal_o),
        .fault_cnt_o(fault_cnt_o), .fault_log_o(fault_log_o), .first_src_o(first_src_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ncyc = 0;
    endtask

    task automatic pulse(input logic [3:0] p);
        fault_i = p;
        tick();
        fault_i = '0;
    endtask

    task automatic recover();
        halt_ack_i = 1'b1;
        tick();
        halt_ack_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_halt", halt_req_o, 0);
        check("rst_resync", resync_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_fatal", fatal_o, 0);
        check("rst_cnt", fault_cnt_o, 0);
        check("rst_log", fault_log_o, 0);
        check("rst_first", first_src_o, 0);

        pulse(4'b0100);
        check("t1_halt", halt_req_o, 1);
        check("t1_busy", busy_o, 1);
        check("t1_noresync", resync_o, 0);
        check("t1_cnt", fault_cnt_o, 1);
        tick();
        tick();
        check("t1_wait_halt", halt_req_o, 1);
        check("t1_wait_resync", resync_o, 0);
        halt_ack_i = 1'b1;
        tick();
        halt_ack_i = 1'b0;
        check("t1_rs1", resync_o, 1);
        check("t1_rs1_halt", halt_req_o, 1);
        tick();
        check("t1_rs2", resync_o, 1);
        tick();
        check("t1_rs_end", resync_o, 0);
        check("t1_idle_busy", busy_o, 0);
        check("t1_idle_halt", halt_req_o, 0);
        check("t1_cnt_end", fault_cnt_o, 1);

        pulse(4'b0001);
        check("t2_ev2_fatal", fatal_o, 0);
        recover();
        pulse(4'b0010);
        check("t2_fatal", fatal_o, 1);
        check("t2_halt", halt_req_o, 1);
        check("t2_noresync", resync_o, 0);
        check("t2_cnt", fault_cnt_o, 3);
        halt_ack_i = 1'b1;
        fault_i = 4'b1111;
        tick();
        halt_ack_i = 1'b0;
        fault_i = '0;
        check("t2_ack_ignored", fatal_o, 1);
        check("t2_fault_ignored", fault_cnt_o, 3);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("t2_clr_fatal", fatal_o, 0);
        check("t2_clr_busy", busy_o, 0);
        check("t2_clr_cnt", fault_cnt_o, 0);

        fault_i = 4'b0001;
        tick();
        check("t4_hold_cnt1", fault_cnt_o, 1);
        tick();
        tick();
        halt_ack_i = 1'b1;
        tick();
        halt_ack_i = 1'b0;
        tick();
        tick();
        check("t4_hold_idle", busy_o, 0);
        check("t4_hold_nocnt", fault_cnt_o, 1);
        tick();
        check("t4_hold_reevent", fault_cnt_o, 2);
        check("t4_hold_halt", halt_req_o, 1);
        fault_i = '0;
        recover();
        clear_i = 1'b1;
        fault_i = 4'b0100;
        tick();
        clear_i = 1'b0;
        fault_i = '0;
        check("t4_clr_ev_cnt", fault_cnt_o, 0);
        check("t4_clr_ev_busy", busy_o, 0);

        do_reset();
        pulse(4'b0001);
        recover();
        pulse(4'b0001);
        recover();
        while (ncyc < 1023) tick();
        pulse(4'b0001);
        check("t4_wrap_halt", halt_req_o, 1);
        check("t4_wrap_nofatal", fatal_o, 0);
        check("t4_wrap_cnt", fault_cnt_o, 3);
        recover();
        pulse(4'b0001);
        check("t4_wrap_ev2_nofatal", fatal_o, 0);
        recover();
        pulse(4'b0001);
        check("t4_wrap_ev3_fatal", fatal_o, 1);
        check("t4_wrap_cnt5", fault_cnt_o, 5);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;

        pulse(4'b0010);
        recover();
        pulse(4'b0010);
        recover();
        while (ncyc < 2100) tick();
        pulse(4'b0010);
        check("t3_halt", halt_req_o, 1);
        check("t3_nofatal", fatal_o, 0);
        check("t3_cnt", fault_cnt_o, 3);
        recover();

        pulse(4'b1000);
        halt_ack_i = 1'b1;
        tick();
        halt_ack_i = 1'b0;
        check("t5_in_resync", resync_o, 1);
        rst = 1'b1;
        tick();
        check("t5_rst_resync", resync_o, 0);
        check("t5_rst_halt", halt_req_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_cnt", fault_cnt_o, 0);
        rst = 1'b0;
        tick();
        check("t5_after_resync", resync_o, 0);
        check("t5_after_busy", busy_o, 0);

        pulse(4'b0110);
        recover();
        pulse(4'b1000);
        recover();
`ifdef CV32E40P_TMR_FAULT_LOG_EN
        check("t6_log", fault_log_o, 4'b1110);
        check("t6_first", first_src_o, 1);
`else
        check("t6_log", fault_log_o, 0);
        check("t6_first", first_src_o, 0);
`endif
        check("t6_cnt", fault_cnt_o, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
